// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: operation and FSM state encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'd0,
    OpSrl = 2'd1,
    OpSra = 2'd2,
    OpRor = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } shift_state_t;

endpackage

// File: rtl/shift_unit_iter_if.sv
// Request/result handshake bundle for shift_unit_iter; slave side is the shifter.
interface shift_unit_iter_if
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  shift_op_t          in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k (<= STEP) positions.
// Rotate only exists when SHIFT_UNIT_ROT_EN is defined; otherwise op 3 behaves as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] d,
  input  logic [KW-1:0]    k,
  input  shift_op_t        op,
  input  logic             sign,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d << k;
    unique case (op)
      OpSrl:   q = d >> k;
      // Sign comes from the operand latched at accept, not the current MSB.
      OpSra:   q = WIDTH'({{WIDTH{sign}}, d} >> k);
`ifdef SHIFT_UNIT_ROT_EN
      OpRor:   q = WIDTH'({d, d} >> k);
`endif
      default: q = d << k;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle SLL/SRL/SRA shifter, up to STEP positions per cycle, valid/ready on both sides.
// Define SHIFT_UNIT_ROT_EN to make op 3 a rotate-right; otherwise op 3 is SLL.
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  shift_unit_iter_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned KW      = $clog2(STEP + 1);
  localparam logic [SHAMT_W:0] StepExt = (SHAMT_W + 1)'(STEP);

  shift_state_t       state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_op_t          op_q, op_d;
  logic               sign_q, sign_d;

  logic [SHAMT_W:0]   rem_ext, k_full;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_q;
  logic               accept;

  assign rem_ext = {1'b0, rem_q};
  assign k_full  = (rem_ext < StepExt) ? rem_ext : StepExt;
  assign k       = KW'(k_full);

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .d   (work_q),
    .k   (k),
    .op  (op_q),
    .sign(sign_q),
    .q   (step_q)
  );

  assign accept = bus.in_valid && (state_q == StIdle) && !flush;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          work_d  = bus.in_data;
          rem_d   = bus.in_shamt;
          op_d    = bus.in_op;
          sign_d  = bus.in_data[WIDTH-1];
          state_d = (bus.in_shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        work_d = step_q;
        rem_d  = rem_q - k_full[SHAMT_W-1:0];
        if (rem_d == '0) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= OpSll;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = work_q;

endmodule
